// File: rtl/period_meter_if.sv
// Signal bundle for period_meter: the measured waveform in, phase counts and strobes out.
interface period_meter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             sig_in;
    logic [WIDTH-1:0] high_cnt;
    logic [WIDTH-1:0] low_cnt;
    logic [WIDTH:0]   period;
    logic             valid;
    logic             stalled;

    // Source/observer side (bench or upstream logic).
    modport master (
        output sig_in,
        input  high_cnt,
        input  low_cnt,
        input  period,
        input  valid,
        input  stalled
    );

    // Meter side.
    modport slave (
        input  sig_in,
        output high_cnt,
        output low_cnt,
        output period,
        output valid,
        output stalled
    );
endinterface

// File: rtl/period_meter.sv
// Measures high and low phase lengths of a slow square wave in clk cycles and
// reports them, plus their sum, with a one-cycle valid strobe. A phase longer
// than TIMEOUT drops the meter back to idle and raises stalled.
module period_meter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1_000_000
) (
    input logic           clk,
    input logic           rst,
    period_meter_if.slave bus
);

    localparam logic [WIDTH-1:0] TimeoutCnt = WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StAcq,
        StFill,
        StRun
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   edge_det;

    logic [WIDTH-1:0] run_q, run_d;

    state_e           state_q;
    logic [WIDTH-1:0] high_q, low_q;
    logic [WIDTH:0]   period_q;
    logic             valid_q;
    logic             stalled_q;

    logic [WIDTH-1:0] high_new, low_new;
    logic [WIDTH:0]   period_new;

    // Synchronise the asynchronous input and keep a delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge decode and phase-counter next state; the counter saturates at TIMEOUT.
    always_comb begin
        s        = sync_q[SYNC_STAGES-1];
        rise     = s & ~s_d_q;
        fall     = ~s & s_d_q;
        edge_det = rise | fall;
        run_d    = run_q;
        if (edge_det) begin
            run_d = WIDTH'(1);
        end else if (run_q < TimeoutCnt) begin
            run_d = run_q + WIDTH'(1);
        end
    end

    // Phase counter: on an edge cycle it holds the length of the phase just ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // Candidate capture values: a fall ends a high phase, a rise ends a low phase.
    always_comb begin
        high_new   = fall ? run_q : high_q;
        low_new    = rise ? run_q : low_q;
        period_new = {1'b0, high_new} + {1'b0, low_new};
    end

    // Acquisition FSM with registered outputs; an edge beats a coincident timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            high_q    <= '0;
            low_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // First edge only opens a phase; the preceding one is partial.
                    if (edge_det) begin
                        state_q   <= StAcq;
                        stalled_q <= 1'b0;
                    end
                end
                StAcq, StFill, StRun: begin
                    if (edge_det) begin
                        high_q   <= high_new;
                        low_q    <= low_new;
                        period_q <= period_new;
                        if (state_q == StAcq) begin
                            state_q <= StFill;
                        end else begin
                            state_q <= StRun;
                            valid_q <= 1'b1;
                        end
                    end else if (run_q == TimeoutCnt) begin
                        state_q   <= StIdle;
                        stalled_q <= 1'b1;
                        high_q    <= '0;
                        low_q     <= '0;
                        period_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.high_cnt = high_q;
    assign bus.low_cnt  = low_q;
    assign bus.period   = period_q;
    assign bus.valid    = valid_q;
    assign bus.stalled  = stalled_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus pushes expected reports, a
// negedge monitor pops and compares them whenever valid is seen.
module tb_period_meter;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #2 clk = ~clk;

    period_meter_if #(.WIDTH(W)) bus ();

    period_meter #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .TIMEOUT    (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic [W:0]   p;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors  = 0;
    int   checks  = 0;
    int   cur_run = 0;
    int   max_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int h, input int l);
        exp_t e;
        e.h = W'(h);
        e.l = W'(l);
        e.p = (W + 1)'(h + l);
        sb.push_back(e);
    endtask

    // Drive a level that is sampled on exactly n rising clock edges.
    task automatic hold(input logic lvl, input int n);
        bus.sig_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.sig_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 high=%0d low=%0d, required no valid (t=%0t)",
                         bus.high_cnt, bus.low_cnt, $time);
            end else begin
                mon_e = sb.pop_front();
                check("high_cnt", 64'(bus.high_cnt), 64'(mon_e.h));
                check("low_cnt", 64'(bus.low_cnt), 64'(mon_e.l));
                check("period", 64'(bus.period), 64'(mon_e.p));
            end
        end else begin
            cur_run = 0;
        end
    end

    initial begin
        bus.sig_in = 1'b0;
        do_reset();
        check("rst_high_cnt", 64'(bus.high_cnt), 0);
        check("rst_low_cnt", 64'(bus.low_cnt), 0);
        check("rst_period", 64'(bus.period), 0);
        check("rst_valid", 64'(bus.valid), 0);
        check("rst_stalled", 64'(bus.stalled), 0);

        // Symmetric 10/10, then phase length changes to 13.
        hold(1'b1, 10);
        hold(1'b0, 10);
        push(10, 10); hold(1'b1, 10);
        push(10, 10); hold(1'b0, 10);
        push(10, 10); hold(1'b1, 10);
        push(10, 10); hold(1'b0, 10);
        push(10, 10); hold(1'b1, 13);
        push(13, 10); hold(1'b0, 13);
        push(13, 13); hold(1'b1, 13);
        check("run_not_stalled", 64'(bus.stalled), 0);

        // Hold the level past TIMEOUT.
        hold(1'b1, 20);
        check("stall_flag", 64'(bus.stalled), 1);
        check("stall_high_cnt", 64'(bus.high_cnt), 0);
        check("stall_low_cnt", 64'(bus.low_cnt), 0);
        check("stall_period", 64'(bus.period), 0);

        // Resume at 4/4: stall clears at first edge, valid at third.
        hold(1'b0, 4);
        check("stall_cleared", 64'(bus.stalled), 0);
        hold(1'b1, 4);
        push(4, 4); hold(1'b0, 4);
        push(4, 4);
        bus.sig_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Reset pulse in the middle of a high phase.
        rst = 1'b1;
        #1;
        check("async_rst_high_cnt", 64'(bus.high_cnt), 0);
        check("async_rst_low_cnt", 64'(bus.low_cnt), 0);
        check("async_rst_period", 64'(bus.period), 0);
        check("async_rst_valid", 64'(bus.valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 7);
        hold(1'b0, 6);
        push(7, 6); hold(1'b1, 7);
        push(7, 6); hold(1'b0, 6);

        // Asymmetric 3 high / 5 low.
        do_reset();
        hold(1'b1, 3);
        hold(1'b0, 5);
        push(3, 5); hold(1'b1, 3);
        push(3, 5); hold(1'b0, 5);
        push(3, 5); hold(1'b1, 3);
        push(3, 5); hold(1'b0, 5);

        // Toggle every clock: valid held high once in RUN.
        do_reset();
        hold(1'b1, 1);
        hold(1'b0, 1);
        for (int i = 0; i < 10; i++) begin
            push(1, 1);
            hold((i % 2 == 0) ? 1'b1 : 1'b0, 1);
        end
        hold(1'b0, 30);
        check("l1_stall_flag", 64'(bus.stalled), 1);

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 0);
        check("valid_run_len", 64'(max_run), 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the high and low phase lengths, in `clk` cycles, of a slow square wave such as the divided `clkout` produced by the team's programmable counter. It recovers the divider setting from the waveform and reports the high-phase count, low-phase count and full period with a one-cycle `valid` strobe. It sits on the receive side of any divided-clock or blink-rate signal used by the colour display logic, and serves as the self-check partner for the divider in benches.

## Interface
- `WIDTH`, 32: width of phase counters and `high_cnt`/`low_cnt`.
- `SYNC_STAGES`, 2: flip-flop stages on `sig_in`; legal range 2..4.
- `TIMEOUT`, 1_000_000: phase length, in cycles, at which a run is declared stalled. Must be ≥2 and < 2^WIDTH.

- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  asynchronous, active-high reset.
- `sig_in`  in  1  measured waveform; may be asynchronous to `clk`.
- `high_cnt`  out  WIDTH  length of the last complete high phase.
- `low_cnt`  out  WIDTH  length of the last complete low phase.
- `period`  out  WIDTH+1  `high_cnt + low_cnt`, full width with no overflow.
- `valid`  out  1  one-cycle strobe; outputs were updated this cycle.
- `stalled`  out  1  level; no edge was seen for `TIMEOUT` cycles.

## Operation
- `sig_in` passes through a `SYNC_STAGES` synchronizer. Its last stage `s` is compared with a registered copy `s_d`:
  - `rise = s & ~s_d`
  - `fall = ~s & s_d`
  - `edge = rise | fall`
- Phase counter `run`:
  - Loads 1 on the cycle after an `edge` cycle.
  - Otherwise increments by 1 per cycle.
  - Stops at `TIMEOUT`.
- Phase length L is the number of `clk` cycles between two consecutive `edge` pulses. A level held for exactly N cycles yields N.
- State machine (binary encoded):
  - IDLE: no edge seen. On `edge`, go to ACQ. Nothing is captured because the phase before the first edge is partial.
  - ACQ: on `edge`, capture L into `high_cnt` if `fall`, or into `low_cnt` if `rise`. Go to FILL. No `valid`.
  - FILL: on `edge`, capture the other phase, update `period`, pulse `valid`, go to RUN.
  - RUN: on every `edge`, capture the just-ended phase, update `period` and pulse `valid`. The other phase count holds its value.
  - ACQ/FILL/RUN: when `run` reaches `TIMEOUT` with no `edge`:
    - go to IDLE
    - set `stalled`
    - clear `high_cnt`, `low_cnt` and `period` to 0
    - no `valid`.
- `stalled` clears on the next `edge`. That edge is treated as the first edge (IDLE→ACQ).
- `edge` and the timeout in the same cycle: `edge` wins and normal capture happens.
- `period` is always the sum of the two registered phase counts, and is updated in the same cycle as them.

## Timing
- Reset (async assert, sync release):
  - synchronizer, `s_d`, `run`, `high_cnt`, `low_cnt`, `period`, `valid` and `stalled` = 0
  - state = IDLE.
- If `sig_in` = 1 at reset release, the resulting synthetic `rise` is taken as the first edge. It is discarded by the IDLE→ACQ path.
- Latency: a `sig_in` level change first sampled at clk edge k produces `edge` in the cycle after edge k+SYNC_STAGES−1. `high_cnt`/`low_cnt`/`period`/`valid` update at clk edge k+SYNC_STAGES.
- `valid` is high for exactly one cycle per accepted edge and never in two consecutive cycles unless L = 1.
- First `valid` after reset or timeout comes at the third edge.
- Reset asserted mid-phase: all outputs go to 0 immediately. The partial phase is lost.
- Minimum L = 1 (input toggling every `clk`): every cycle is an edge and `valid` is high continuously in RUN.

## Test plan
- clk period 4 ns, `sig_in` toggles every 10 clk cycles from reset -> first `valid` at third edge; `high_cnt`=10, `low_cnt`=10, `period`=20 on every following `valid`.
- Asymmetric input, 3 cycles high / 5 cycles low -> `high_cnt`=3 updated on falls, `low_cnt`=5 updated on rises, `period`=8, one `valid` per edge.
- Phase length changed mid-run from 10 to 13 -> the first `valid` after the change shows the mixed pair (13,10) with `period`=23. The next `valid` shows `period`=26.
- `TIMEOUT`=16, `sig_in` held constant for 20 cycles after RUN -> `stalled`=1 and counts = 0 on the 16th cycle, no `valid`. Resuming at 4/4 -> `stalled` drops at the first edge and `valid` with `period`=8 at the third.
- `rst` pulsed for 1 cycle in the middle of a high phase -> outputs 0 asynchronously. After release, no `valid` until two full phases complete; values then match the input.
- `sig_in` toggled every clk cycle -> in RUN `high_cnt`=1, `low_cnt`=1, `period`=2 and `valid` held high.
